dmem_ctrl_arb: RTL and testbench

Data-memory controller and arbiter that shares the single data memory port (addr / wen / wdata / wdata_mask / rdata) between NREQ requesters, typically the core load/store unit and a debug/loader port. It arbitrates round-robin and sequences each access through a fixed three-phase FSM. It generates the byte write mask from an access size, sign- or zero-extends load data, and returns a per-requester response over a valid/ready handshake.

---
 rtl/dmem_ctrl_pkg.sv | 52 +++++
 rtl/dmem_ctrl_arb_if.sv | 41 ++++
 rtl/dmem_rr_arb.sv | 46 ++++
 rtl/dmem_ctrl_arb.sv | 144 ++++++++++++++
 tb/tb_dmem_ctrl_arb.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller/arbiter.
// Helpers work on the widest supported data path (64 bits) and callers truncate.
package dmem_ctrl_pkg;

  localparam int unsigned MaxDw = 64;
  localparam int unsigned MaxMw = MaxDw / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StRsp
  } state_e;

  // An access is legal only if all of its bytes fit in one memory word.
  function automatic logic size_legal(size_e size, int unsigned mwidth);
    return (32'd1 << size) <= mwidth;
  endfunction

  function automatic logic [MaxMw-1:0] size_to_mask(size_e size, int unsigned mwidth);
    logic [MaxMw-1:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0f;
      default: mask = 8'hff;
    endcase
    if (!size_legal(size, mwidth)) begin
      mask = '0;
    end
    return mask;
  endfunction

  function automatic logic [MaxDw-1:0] extend_load(logic [MaxDw-1:0] data, size_e size,
                                                    logic is_signed);
    logic [MaxDw-1:0] res;
    case (size)
      SZ_B:    res = {{56{is_signed & data[7]}}, data[7:0]};
      SZ_H:    res = {{48{is_signed & data[15]}}, data[15:0]};
      SZ_W:    res = {{32{is_signed & data[31]}}, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ctrl_arb_if.sv
// Requester, response and memory-port signals of the data-memory controller.
// The controller uses the slave modport; requesters and the memory use master.
interface dmem_ctrl_arb_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
);
  localparam int unsigned MWIDTH = DWIDTH / 8;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [2*NREQ-1:0]      req_size;
  logic [NREQ-1:0]        req_signed;
  logic [AWIDTH*NREQ-1:0] req_addr;
  logic [DWIDTH*NREQ-1:0] req_wdata;

  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [DWIDTH-1:0]      rsp_rdata;
  logic                   rsp_err;

  logic [AWIDTH-1:0]      mem_addr;
  logic                   mem_wen;
  logic [DWIDTH-1:0]      mem_wdata;
  logic [MWIDTH-1:0]      mem_wdata_mask;
  logic [DWIDTH-1:0]      mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wen, mem_wdata,
           mem_wdata_mask
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wen, mem_wdata,
           mem_wdata_mask
  );

endinterface

// File: rtl/dmem_rr_arb.sv
// Round-robin arbiter: priority starts just after the last granted index.
// The pointer only moves when upd_en is pulsed, so a grant can be held off freely.
module dmem_rr_arb #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            upd_en,
  input  logic [IW-1:0]   upd_idx,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [IW-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (upd_en) begin
      ptr_q <= upd_idx;
    end
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!grant_any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl_arb.sv
// Data-memory controller: round-robin arbitration, IDLE/MEM/RSP sequencing, byte masks
// and load extension. Define DMEM_CTRL_ALIGN_CHECK_EN to reject misaligned addresses.
module dmem_ctrl_arb
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  dmem_ctrl_arb_if.slave  bus
);

  localparam int unsigned MWIDTH = DWIDTH / 8;
  localparam int unsigned IW     = $clog2(NREQ);

  state_e            state_q;
  logic              cmd_we_q;
  size_e             cmd_size_q;
  logic              cmd_sgn_q;
  logic              cmd_err_q;
  logic [IW-1:0]     cmd_idx_q;

  logic [AWIDTH-1:0] mem_addr_q;
  logic              mem_wen_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic [MWIDTH-1:0] mem_mask_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DWIDTH-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;
  logic              rsp_hs;

  logic              sel_we;
  size_e             sel_size;
  logic              sel_sgn;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic              sel_misal;
  logic              sel_err;

  assign rsp_hs = (state_q == StRsp) && bus.rsp_ready[cmd_idx_q];

  dmem_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (bus.req_valid),
    .upd_en   (rsp_hs),
    .upd_idx  (cmd_idx_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  assign sel_we    = bus.req_we[grant_idx];
  assign sel_size  = size_e'(bus.req_size[2*grant_idx +: 2]);
  assign sel_sgn   = bus.req_signed[grant_idx];
  assign sel_addr  = bus.req_addr[AWIDTH*grant_idx +: AWIDTH];
  assign sel_wdata = bus.req_wdata[DWIDTH*grant_idx +: DWIDTH];

`ifdef DMEM_CTRL_ALIGN_CHECK_EN
  assign sel_misal = |(sel_addr & AWIDTH'(MWIDTH - 1));
`else
  assign sel_misal = 1'b0;
`endif

  assign sel_err = !size_legal(sel_size, MWIDTH) || sel_misal;

  // Gated by reset so the ready is low while rst_n is held, even with requests pending.
  assign bus.req_ready      = grant & {NREQ{rst_n && (state_q == StIdle)}};
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wdata_mask = mem_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_we_q    <= 1'b0;
      cmd_size_q  <= SZ_B;
      cmd_sgn_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_idx_q   <= '0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            cmd_we_q   <= sel_we;
            cmd_size_q <= sel_size;
            cmd_sgn_q  <= sel_sgn;
            cmd_err_q  <= sel_err;
            cmd_idx_q  <= grant_idx;
            // Rejected accesses never reach the memory port, not even the address.
            if (!sel_err) begin
              mem_addr_q <= sel_addr;
              if (sel_we) begin
                mem_wdata_q <= sel_wdata;
                mem_wen_q   <= 1'b1;
                mem_mask_q  <= MWIDTH'(size_to_mask(sel_size, MWIDTH));
              end
            end
            state_q <= StMem;
          end
        end
        StMem: begin
          mem_wen_q   <= 1'b0;
          mem_mask_q  <= '0;
          rsp_err_q   <= cmd_err_q;
          rsp_valid_q <= NREQ'(1) << cmd_idx_q;
          if (cmd_err_q || cmd_we_q) begin
            rsp_rdata_q <= '0;
          end else begin
            rsp_rdata_q <= DWIDTH'(extend_load(MaxDw'(bus.mem_rdata), cmd_size_q, cmd_sgn_q));
          end
          state_q <= StRsp;
        end
        StRsp: begin
          if (bus.rsp_ready[cmd_idx_q]) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl_arb.sv
// Bench for dmem_ctrl_arb: transaction-level model checked every cycle, directed cases
// with literal expectations, then randomized traffic. Honours DMEM_CTRL_ALIGN_CHECK_EN.
module tb_dmem_ctrl_arb;
  import dmem_ctrl_pkg::*;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned AWIDTH = 8;
  localparam int unsigned DWIDTH = 32;
  localparam int unsigned MWIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_init;
  always #5 clk = ~clk;

  dmem_ctrl_arb_if #(.NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

  dmem_ctrl_arb #(
    .NREQ  (NREQ),
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory seen by the DUT: one 32-bit word per address, byte lanes selected by mask.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wdata_mask[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int n_vec, n_err, cycle;

  // Requester-side stimulus
  logic [NREQ-1:0] v, we, sg, rr;
  logic [1:0]  sz [NREQ];
  logic [7:0]  ad [NREQ];
  logic [31:0] wd [NREQ];

  // Reference model state
  logic [31:0] ref_mem [256];
  int          ph, ptr, cg;
  logic        c_we, c_sgn, c_err;
  logic [1:0]  c_size;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata;
  logic [31:0] e_rdata;
  logic        e_err;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;
  logic [NREQ-1:0] accepted;

  // Observations for directed checks
  logic [3:0]  seen_mask;
  int          wen_pulses, n_grants;
  logic [31:0] seen_rdata;
  logic        seen_err, rsp_done;
  logic [NREQ-1:0] seen_ready, cur_rsp_valid;
  int          grant_cyc[$];
  logic [NREQ-1:0] grant_vec[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] vv, int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (vv[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_ext(logic [31:0] w, int size, logic sgn);
    int nbits;
    logic [63:0] x, m;
    nbits = 8 << size;
    m = (64'd1 << nbits) - 64'd1;
    x = {32'd0, w} & m;
    if (sgn && x[nbits-1]) x = x | ~m;
    return x[31:0];
  endfunction

  task automatic model_reset();
    ph = 0; ptr = NREQ - 1; cg = 0;
    c_we = 0; c_sgn = 0; c_err = 0; c_size = 0; c_addr = 0; c_wdata = 0;
    e_rdata = 0; e_err = 0; last_addr = 0; last_wdata = 0; accepted = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wen"}, bus.mem_wen, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_mask"}, bus.mem_wdata_mask, 0);
  endtask

  task automatic drive();
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_signed = sg;
    bus.rsp_ready  = rr;
    for (int r = 0; r < NREQ; r++) begin
      bus.req_size[2*r +: 2]   = sz[r];
      bus.req_addr[8*r +: 8]   = ad[r];
      bus.req_wdata[32*r +: 32] = wd[r];
    end
  endtask

  // Compare DUT against the model, record observations, then advance the model one cycle.
  task automatic check_cycle();
    int g;
    logic e_wen;
    logic [3:0] e_mask;
    logic [NREQ-1:0] e_ready, e_valid;
    g = (ph == 0) ? rr_pick(bus.req_valid, ptr) : -1;
    e_ready = (g >= 0) ? NREQ'(1 << g) : '0;
    e_wen   = (ph == 1) && c_we && !c_err;
    e_mask  = e_wen ? 4'((32'd1 << (32'd1 << c_size)) - 32'd1) : 4'd0;
    e_valid = (ph == 2) ? NREQ'(1 << cg) : '0;
    chk("req_ready", bus.req_ready, e_ready);
    chk("mem_wen", bus.mem_wen, e_wen);
    chk("mem_mask", bus.mem_wdata_mask, e_mask);
    chk("mem_addr", bus.mem_addr, last_addr);
    chk("mem_wdata", bus.mem_wdata, last_wdata);
    chk("rsp_valid", bus.rsp_valid, e_valid);
    if (ph == 2) begin
      chk("rsp_rdata", bus.rsp_rdata, e_rdata);
      chk("rsp_err", bus.rsp_err, e_err);
    end

    seen_ready    = bus.req_ready;
    cur_rsp_valid = bus.rsp_valid;
    if (bus.req_ready != 0) begin
      n_grants++;
      grant_cyc.push_back(cycle);
      grant_vec.push_back(bus.req_ready);
    end
    seen_mask = seen_mask | bus.mem_wdata_mask;
    if (bus.mem_wen) wen_pulses++;
    rsp_done = 1'b0;
    if (bus.rsp_valid != 0) begin
      seen_rdata = bus.rsp_rdata;
      seen_err   = bus.rsp_err;
      if ((bus.rsp_valid & bus.rsp_ready) != 0) rsp_done = 1'b1;
    end

    accepted = '0;
    case (ph)
      0: if (g >= 0) begin
        cg      = g;
        c_we    = bus.req_we[g];
        c_size  = bus.req_size[2*g +: 2];
        c_sgn   = bus.req_signed[g];
        c_addr  = bus.req_addr[8*g +: 8];
        c_wdata = bus.req_wdata[32*g +: 32];
        c_err   = (32'd1 << c_size) > MWIDTH;
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
        if ((c_addr % MWIDTH) != 0) c_err = 1'b1;
`endif
        if (!c_err) begin
          last_addr = c_addr;
          if (c_we) last_wdata = c_wdata;
        end
        accepted[g] = 1'b1;
        ph = 1;
      end
      1: begin
        e_err   = c_err;
        e_rdata = 0;
        if (!c_err && c_we) begin
          for (int b = 0; b < (1 << c_size); b++) ref_mem[c_addr][8*b +: 8] = c_wdata[8*b +: 8];
        end else if (!c_err) begin
          e_rdata = model_ext(ref_mem[c_addr], int'(c_size), c_sgn);
        end
        ph = 2;
      end
      default: if (bus.rsp_ready[cg]) begin
        ptr = cg;
        ph  = 0;
      end
    endcase
    cycle++;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    seen_mask = 0; wen_pulses = 0; seen_rdata = 0; seen_err = 0;
  endtask

  task automatic do_txn(input int r, input logic w, input logic [1:0] s, input logic sgn,
                        input logic [7:0] a, input logic [31:0] d);
    logic done;
    v = '0; v[r] = 1'b1; we[r] = w; sz[r] = s; sg[r] = sgn; ad[r] = a; wd[r] = d; rr = '1;
    clear_obs();
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (accepted[r]) v[r] = 1'b0;
      if (rsp_done) done = 1'b1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL txn_timeout: requester %0d got no response, expected one within 20 cycles", r);
    end
  endtask

  task automatic drain(input int n);
    rr = '1;
    for (int k = 0; k < n; k++) begin
      step();
      for (int r = 0; r < NREQ; r++) if (accepted[r]) v[r] = 1'b0;
    end
    v = '0;
  endtask

  initial begin
    int g0, w0, k;
    logic [31:0] first;
    n_vec = 0; n_err = 0; cycle = 0; n_grants = 0;
    rst_n = 1'b0; mem_init = 1'b1;
    v = '0; we = '0; sg = '0; rr = '0;
    for (int r = 0; r < NREQ; r++) begin sz[r] = 0; ad[r] = 0; wd[r] = 0; end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    clear_obs();
    model_reset();

    // Reset values, with requests pending so req_ready gating is exercised
    v = 2'b11; drive();
    #1;
    chk_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst_n = 1'b1;

    // Both valid, rsp_ready high: grants alternate 0,1,0,1 every 3 cycles
    grant_cyc.delete(); grant_vec.delete();
    rr = '1;
    for (int r = 0; r < NREQ; r++) begin we[r] = 0; sz[r] = SZ_W; sg[r] = 0; end
    for (int n = 0; n < 12; n++) begin
      for (int r = 0; r < NREQ; r++) if (accepted[r] || n == 0) ad[r] = 8'(4 * $urandom_range(0, 15));
      step();
    end
    v = '0;
    chk("alt_count", grant_cyc.size(), 4);
    for (int i = 0; i < 4 && i < grant_cyc.size(); i++) begin
      chk("alt_idx", grant_vec[i], (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i > 0) chk("alt_gap", grant_cyc[i] - grant_cyc[i-1], 3);
    end
    step();

    do_txn(0, 1'b1, SZ_W, 1'b0, 8'h10, 32'hDEADBEEF);
    chk("sw_mask", seen_mask, 4'hF);
    chk("sw_wen_pulses", wen_pulses, 1);
    chk("sw_err", seen_err, 0);
    do_txn(0, 1'b0, SZ_W, 1'b0, 8'h10, 32'h0);
    chk("lw_rdata", seen_rdata, 32'hDEADBEEF);
    chk("lw_err", seen_err, 0);
    chk("lw_model", e_rdata, 32'hDEADBEEF);

    do_txn(0, 1'b1, SZ_B, 1'b0, 8'h04, 32'h00000080);
    chk("sb_mask", seen_mask, 4'h1);
    do_txn(0, 1'b0, SZ_B, 1'b1, 8'h04, 32'h0);
    chk("lb_signed", seen_rdata, 32'hFFFFFF80);
    do_txn(1, 1'b0, SZ_B, 1'b0, 8'h04, 32'h0);
    chk("lbu_unsigned", seen_rdata, 32'h00000080);

    do_txn(0, 1'b1, SZ_D, 1'b0, 8'h20, 32'h12345678);
    chk("sd_wen_pulses", wen_pulses, 0);
    chk("sd_err", seen_err, 1);
    chk("sd_rdata", seen_rdata, 0);

    do_txn(0, 1'b1, SZ_W, 1'b0, 8'h06, 32'hCAFEF00D);
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    chk("mis_err", seen_err, 1);
    chk("mis_wen_pulses", wen_pulses, 0);
    chk("mis_mem_unchanged", mem[6], init_word(6));
`else
    chk("mis_err", seen_err, 0);
    chk("mis_wen_pulses", wen_pulses, 1);
`endif

    // Response stall: rsp_ready low, requester 1 waiting
    v = '0; v[0] = 1; we[0] = 0; sz[0] = SZ_W; sg[0] = 0; ad[0] = 8'h10;
    we[1] = 0; sz[1] = SZ_H; sg[1] = 1; ad[1] = 8'h04;
    rr = '0;
    clear_obs();
    k = 0;
    cur_rsp_valid = '0;
    while (cur_rsp_valid == 0 && k < 10) begin
      step();
      if (accepted[0]) begin v[0] = 0; v[1] = 1; end
      k++;
    end
    chk("stall_rsp_seen", cur_rsp_valid, 2'b01);
    first = seen_rdata;
    chk("stall_rdata_val", first, 32'hDEADBEEF);
    g0 = n_grants; w0 = wen_pulses;
    repeat (5) begin
      step();
      chk("stall_valid", cur_rsp_valid, 2'b01);
      chk("stall_rdata", seen_rdata, first);
    end
    chk("stall_grants", n_grants - g0, 0);
    chk("stall_wen", wen_pulses - w0, 0);
    drain(12);

    // Reset asserted while a load is in MEM
    v = '0; v[0] = 1; we[0] = 0; sz[0] = SZ_W; ad[0] = 8'h10; rr = '1;
    step();
    chk("rst_grant", accepted, 2'b01);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = 2'b11; we = '0; sz[0] = SZ_W; sz[1] = SZ_W; ad[0] = 8'h10; ad[1] = 8'h08;
    step();
    chk("rst_first_winner", seen_ready, 2'b01);
    drain(12);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (accepted[r] || !v[r]) begin
          if ($urandom_range(0, 2) != 0) begin
            v[r]  = 1'b1;
            we[r] = 1'($urandom_range(0, 1));
            sz[r] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sg[r] = 1'($urandom_range(0, 1));
            ad[r] = 8'($urandom_range(0, 15));
            wd[r] = $urandom;
          end else begin
            v[r] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v[r] = 1'b0;
        end
        rr[r] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    drain(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
